// File: rtl/bch_dec_corr_pipe_univ.sv
// -----------------------------------------------------------------------------
// bch_dec_corr_pipe_univ
//
// Streaming, pipelined double-error-correcting BCH decoder/corrector.
// A received word {d_i, ecc_i} enters through a valid/ready slave port. The
// corrected data and its status leave through a valid/ready master port.
// Pipeline with P_PIPE_MID = 1: S1 (syndromes), S2 (register only), output
// (pattern decode plus correction). With P_PIPE_MID = 0 the S2 register is
// removed.
//
// Code: shortened narrow-sense binary BCH, t = 2, over GF(2^m). m is the
// smallest value with 2^m - 1 >= P_D_WIDTH + 2m, so E = 2m ECC bits.
// Codeword bit p is the coefficient of x^p:
//   ecc_i[j] -> x^j
//   d_i[i]   -> x^(E+i)
// The H column of position p is {alpha^(3p), alpha^p}, which gives the
// syndrome vector {r(alpha^3), r(alpha)}. The generator polynomial is
// m1(x)*m3(x), so an encoder that divides d(x)*x^E by it is compatible.
//
// Optional feature: define BCH_DEC_ERR_CNT_EN to build the saturating
// error statistics counters. Without it cnt_clr_i is ignored and both
// counter outputs read 0.
//
// Ports:
//   clk_i       in   1            clock, rising edge
//   rst_n_i     in   1            asynchronous active-low reset
//   s_valid_i   in   1            input word valid
//   s_ready_o   out  1            block can accept an input word
//   d_i         in   P_D_WIDTH    received data
//   ecc_i       in   E            received ECC bits
//   m_valid_o   out  1            output word valid
//   m_ready_i   in   1            consumer accepts the output word
//   d_o         out  P_D_WIDTH    corrected data (d_i ^ msk_o)
//   msk_o       out  P_D_WIDTH    applied error mask
//   err_det_o   out  1            syndrome nonzero
//   n_corr_o    out  2            number of data bits corrected
//   cnt_clr_i   in   1            clear the statistics counters
//   cnt_det_o   out  P_CNT_WIDTH  words seen with err_det_o = 1
//   cnt_corr_o  out  P_CNT_WIDTH  words seen with n_corr_o != 0
// -----------------------------------------------------------------------------

package bch_dec_corr_pipe_univ_pkg;

   // Field order m: the smallest m with 2^m - 1 >= data + 2m.
   function automatic int fn_gf_m(input int d_width);
      int m;
      m = 10;
      for (int k = 10; k >= 3; k--) begin
         if (((1 << k) - 1) >= (d_width + 2 * k)) m = k;
      end
      return m;
   endfunction

   function automatic int fn_ecc_synd_width(input int d_width);
      return 2 * fn_gf_m(d_width);
   endfunction

   function automatic logic [15:0] fn_prim_poly(input int m);
      logic [15:0] p;
      case (m)
         3:       p = 16'h000B;
         4:       p = 16'h0013;
         5:       p = 16'h0025;
         6:       p = 16'h0043;
         7:       p = 16'h0089;
         8:       p = 16'h011D;
         9:       p = 16'h0211;
         default: p = 16'h0409;
      endcase
      return p;
   endfunction

   // alpha^e in GF(2^m), in the polynomial basis.
   function automatic logic [15:0] fn_gf_pow(input int m, input int e);
      logic [15:0] a;
      int          ee;
      a  = 16'd1;
      ee = e % ((1 << m) - 1);
      for (int k = 0; k < ee; k++) begin
         a = a << 1;
         if (a[m]) a = a ^ fn_prim_poly(m);
      end
      return a;
   endfunction

   // Parity-check column for codeword position p: {alpha^(3p), alpha^p}.
   function automatic logic [31:0] fn_h_col(input int d_width, input int p);
      int          m;
      logic [31:0] lo;
      logic [31:0] hi;
      m  = fn_gf_m(d_width);
      lo = 32'(fn_gf_pow(m, p));
      hi = 32'(fn_gf_pow(m, 3 * p));
      return (hi << m) | lo;
   endfunction

endpackage

module bch_dec_corr_pipe_univ #(
   parameter int P_D_WIDTH   = 32,
   parameter int P_PIPE_MID  = 1,
   parameter int P_CNT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   s_valid_i,
   output logic                   s_ready_o,
   input  logic [P_D_WIDTH-1:0]   d_i,
   input  logic [bch_dec_corr_pipe_univ_pkg::fn_ecc_synd_width(P_D_WIDTH)-1:0] ecc_i,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic [P_D_WIDTH-1:0]   d_o,
   output logic [P_D_WIDTH-1:0]   msk_o,
   output logic                   err_det_o,
   output logic [1:0]             n_corr_o,
   input  logic                   cnt_clr_i,
   output logic [P_CNT_WIDTH-1:0] cnt_det_o,
   output logic [P_CNT_WIDTH-1:0] cnt_corr_o
);

   localparam int E    = bch_dec_corr_pipe_univ_pkg::fn_ecc_synd_width(P_D_WIDTH);
   localparam int N    = P_D_WIDTH + E;
   localparam int NC_W = $clog2(P_D_WIDTH + 1);

   // Handshake: a word moves across a port on a rising edge where valid and
   // ready are both high. A producer holds valid and its payload unchanged
   // until that happens, and ready never depends on valid of the same port.

   // --------------------------------------------------------------------------
   // Parity-check matrix, one constant column per codeword position
   // --------------------------------------------------------------------------
   logic [E-1:0] h_col [N];

   for (genvar p = 0; p < N; p++) begin : g_col
      localparam logic [31:0] HC = bch_dec_corr_pipe_univ_pkg::fn_h_col(P_D_WIDTH, p);
      assign h_col[p] = HC[E-1:0];
   end

   // --------------------------------------------------------------------------
   // Syndrome of the incoming word
   // --------------------------------------------------------------------------
   logic [N-1:0] cw_in;
   logic [E-1:0] syn_in;

   assign cw_in = {d_i, ecc_i};

   always_comb begin
      syn_in = '0;
      for (int p = 0; p < N; p++) begin
         if (cw_in[p]) syn_in = syn_in ^ h_col[p];
      end
   end

   // --------------------------------------------------------------------------
   // Stall control
   //   A stage loads when its predecessor is valid and it is empty or
   //   advancing. A stage advances when its successor loads. A bubble
   //   anywhere is therefore filled even while the output is stalled.
   // --------------------------------------------------------------------------
   logic                 s1_valid;
   logic [P_D_WIDTH-1:0] s1_d;
   logic [E-1:0]         s1_syn;
   logic                 s1_load;
   logic                 s1_adv;

   // The stage feeding the decode/output register.
   logic                 dec_valid;
   logic [P_D_WIDTH-1:0] dec_d;
   logic [E-1:0]         dec_syn;
   logic                 out_load;

   assign out_load  = dec_valid & (~m_valid_o | m_ready_i);
   assign s_ready_o = ~s1_valid | s1_adv;
   assign s1_load   = s_valid_i & s_ready_o;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid <= 1'b0;
         s1_d     <= '0;
         s1_syn   <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_d     <= d_i;
         s1_syn   <= syn_in;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   if (P_PIPE_MID != 0) begin : g_mid
      logic                 s2_valid;
      logic [P_D_WIDTH-1:0] s2_d;
      logic [E-1:0]         s2_syn;
      logic                 s2_load;

      assign s2_load = s1_valid & (~s2_valid | out_load);
      assign s1_adv  = s2_load;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            s2_valid <= 1'b0;
            s2_d     <= '0;
            s2_syn   <= '0;
         end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_d     <= s1_d;
            s2_syn   <= s1_syn;
         end else if (out_load) begin
            s2_valid <= 1'b0;
         end
      end

      assign dec_valid = s2_valid;
      assign dec_d     = s2_d;
      assign dec_syn   = s2_syn;
   end else begin : g_no_mid
      assign s1_adv    = out_load;
      assign dec_valid = s1_valid;
      assign dec_d     = s1_d;
      assign dec_syn   = s1_syn;
   end

   // --------------------------------------------------------------------------
   // Error-pattern decode
   //   Data bit i is in error when the syndrome equals its own column (single
   //   error) or its column XOR any other column (double error, where the
   //   partner may be a data or an ECC bit). With distance 5 every pattern of
   //   weight <= 2 has a unique syndrome, so the hits never conflict. An
   //   ECC-only error hits no data bit. A mask heavier than 2 can only come
   //   from an uncorrectable pattern and is discarded.
   // --------------------------------------------------------------------------
   logic [P_D_WIDTH-1:0] mask_raw;
   logic [P_D_WIDTH-1:0] dec_mask;
   logic [NC_W-1:0]      mask_wt;
   logic [1:0]           dec_ncorr;

   always_comb begin
      mask_raw = '0;
      for (int i = 0; i < P_D_WIDTH; i++) begin
         logic hit;
         hit = (dec_syn == h_col[E+i]);
         for (int k = 0; k < N; k++) begin
            if ((k != E + i) && (dec_syn == (h_col[E+i] ^ h_col[k]))) hit = 1'b1;
         end
         mask_raw[i] = hit;
      end
   end

   always_comb begin
      mask_wt = '0;
      for (int i = 0; i < P_D_WIDTH; i++) begin
         mask_wt = mask_wt + NC_W'(mask_raw[i]);
      end
   end

   always_comb begin
      dec_mask  = '0;
      dec_ncorr = 2'd0;
      if (mask_wt <= NC_W'(2)) begin
         dec_mask  = mask_raw;
         dec_ncorr = mask_wt[1:0];
      end
   end

   // --------------------------------------------------------------------------
   // Output register. The payload changes only on a load, so it is stable
   // while m_valid_o is high and m_ready_i is low.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         m_valid_o <= 1'b0;
         d_o       <= '0;
         msk_o     <= '0;
         err_det_o <= 1'b0;
         n_corr_o  <= 2'd0;
      end else if (out_load) begin
         m_valid_o <= 1'b1;
         d_o       <= dec_d ^ dec_mask;
         msk_o     <= dec_mask;
         err_det_o <= |dec_syn;
         n_corr_o  <= dec_ncorr;
      end else if (m_ready_i) begin
         m_valid_o <= 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Statistics counters
   // --------------------------------------------------------------------------
`ifdef BCH_DEC_ERR_CNT_EN
   logic                   out_fire;
   logic [P_CNT_WIDTH-1:0] cnt_det_q;
   logic [P_CNT_WIDTH-1:0] cnt_corr_q;

   assign out_fire = m_valid_o & m_ready_i;

   // A clear wins over an increment in the same cycle. Both counters
   // saturate at all-ones.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_det_q  <= '0;
         cnt_corr_q <= '0;
      end else if (cnt_clr_i) begin
         cnt_det_q  <= '0;
         cnt_corr_q <= '0;
      end else begin
         if (out_fire && err_det_o && (cnt_det_q != '1))
            cnt_det_q <= cnt_det_q + P_CNT_WIDTH'(1);
         if (out_fire && (n_corr_o != 2'd0) && (cnt_corr_q != '1))
            cnt_corr_q <= cnt_corr_q + P_CNT_WIDTH'(1);
      end
   end

   assign cnt_det_o  = cnt_det_q;
   assign cnt_corr_o = cnt_corr_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr_i;
   assign cnt_det_o      = '0;
   assign cnt_corr_o     = '0;
`endif

endmodule
